// File: rtl/ram_rd_stream_if.sv
// ram_rd_stream_if: groups the command, RAM read-port and output-stream signals of ram_rd_stream.
// Latency: none, wires only.
// Backpressure: carries m_valid/m_ready; cmd_valid/cmd_ready is a plain handshake.
// Modports: master = the streaming engine, slave = the surrounding RAM/consumer/commander.
// Optional: RAM_RD_STREAM_LAST_EN adds m_last to the stream group.
interface ram_rd_stream_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          r_en;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef RAM_RD_STREAM_LAST_EN
  logic          m_last;
`endif
  logic          busy;
  logic          done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, r_data, m_ready,
    output cmd_ready, r_en, r_addr, m_valid, m_data,
`ifdef RAM_RD_STREAM_LAST_EN
    output m_last,
`endif
    output busy, done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, r_data, m_ready,
    input  cmd_ready, r_en, r_addr, m_valid, m_data,
`ifdef RAM_RD_STREAM_LAST_EN
    input  m_last,
`endif
    input  busy, done
  );
endinterface

// File: rtl/ram_rd_stream.sv
// ram_rd_stream: burst read engine; drives the RAM read port one address per cycle into a 4-entry FIFO streamed out on m_valid/m_ready.
// Latency: command accepted at edge E0 -> r_en in the following cycle -> m_valid after edge E2; 1 beat/cycle sustained.
// Backpressure: a read is issued only while FIFO occupancy plus outstanding reads stays below 4, so m_ready low never drops data.
// Ports: clk, rst (synchronous, active-high); bus (ram_rd_stream_if.master) carries cmd_*, r_en/r_addr/r_data, m_valid/m_ready/m_data, busy, done.
// Optional: define RAM_RD_STREAM_LAST_EN to add m_last, stored with each FIFO entry and high on the final beat of a burst.
module ram_rd_stream #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  ram_rd_stream_if.master bus
);

  localparam int DEPTH = 4;
`ifdef RAM_RD_STREAM_LAST_EN
  localparam int FW = DW + 1;
`else
  localparam int FW = DW;
`endif
  localparam logic [AW:0] LEN_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  state_t state, state_nxt;

  logic [AW:0]   rem;        // reads still to issue
  logic          r_en_q;
  logic [AW-1:0] r_addr_q;
  logic          rd_vld;     // r_data carries the read issued last cycle
  logic [FW-1:0] fifo_mem [DEPTH];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    cnt;

  logic          accept;
  logic          len_zero;
  logic          push;
  logic          pop;
  logic [3:0]    occ_proj;
  logic          credit_ok;
  logic          issue_run;
  logic          drain_done;
  logic [FW-1:0] push_dat;
  logic [FW-1:0] head;
  logic          cmd_ready_c;
  logic          busy_c;
  logic          done_c;

`ifdef RAM_RD_STREAM_LAST_EN
  logic          r_last_q;   // the read on the RAM port this cycle is the burst's last
  logic          rd_last;    // r_data this cycle is the burst's last beat
  assign push_dat = {rd_last, bus.r_data};
`else
  assign push_dat = bus.r_data;
`endif

  assign accept   = (state == IDLE) && bus.cmd_valid;
  assign len_zero = (bus.cmd_len == '0);
  assign push     = rd_vld;
  assign pop      = (cnt != 3'd0) && bus.m_ready;

  // Entries the FIFO must eventually hold: after this edge's push/pop, plus
  // the read currently on the RAM port. A new read may go out only if it
  // still fits, so the FIFO can never overflow whatever m_ready does.
  assign occ_proj  = {1'b0, cnt} + {3'b000, rd_vld} + {3'b000, r_en_q} - {3'b000, pop};
  assign credit_ok = (occ_proj < 4'(DEPTH));
  assign issue_run = (state == RUN) && (rem != '0) && credit_ok;

  // Burst is finished once nothing is outstanding and the last entry leaves
  // the FIFO at this edge (or it is already empty).
  assign drain_done = !r_en_q && !rd_vld &&
                      ((cnt == 3'd0) || ((cnt == 3'd1) && pop));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = len_zero ? FIN : RUN;
      RUN:   if ((rem == '0) || (issue_run && (rem == LEN_ONE))) state_nxt = DRAIN;
      DRAIN: if (drain_done) state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cmd_ready_c = 1'b0;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    case (state)
      IDLE:    cmd_ready_c = 1'b1;
      RUN:     busy_c      = 1'b1;
      DRAIN:   busy_c      = 1'b1;
      FIN:     done_c      = 1'b1;
      default: cmd_ready_c = 1'b0;
    endcase
  end

  // Read issue and FIFO datapath. The first read of a burst goes out
  // straight from the accepting edge so r_en appears the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      r_en_q   <= 1'b0;
      r_addr_q <= '0;
      rd_vld   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
`ifdef RAM_RD_STREAM_LAST_EN
      r_last_q <= 1'b0;
      rd_last  <= 1'b0;
`endif
    end else begin
      rd_vld <= r_en_q;
`ifdef RAM_RD_STREAM_LAST_EN
      rd_last <= r_last_q;
`endif
      if (accept && !len_zero) begin
        r_en_q   <= 1'b1;
        r_addr_q <= bus.cmd_addr;
        rem      <= bus.cmd_len - LEN_ONE;
`ifdef RAM_RD_STREAM_LAST_EN
        r_last_q <= (bus.cmd_len == LEN_ONE);
`endif
      end else if (issue_run) begin
        r_en_q   <= 1'b1;
        r_addr_q <= r_addr_q + AW'(1);
        rem      <= rem - LEN_ONE;
`ifdef RAM_RD_STREAM_LAST_EN
        r_last_q <= (rem == LEN_ONE);
`endif
      end else begin
        r_en_q <= 1'b0;
`ifdef RAM_RD_STREAM_LAST_EN
        r_last_q <= 1'b0;
`endif
      end

      if (push) begin
        fifo_mem[wr_ptr] <= push_dat;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      cnt <= cnt + 3'(push) - 3'(pop);
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (cnt == 3'(DEPTH))));

  assign head          = fifo_mem[rd_ptr];
  assign bus.cmd_ready = cmd_ready_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.r_en      = r_en_q;
  assign bus.r_addr    = r_addr_q;
  assign bus.m_valid   = (cnt != 3'd0);
  assign bus.m_data    = head[DW-1:0];
`ifdef RAM_RD_STREAM_LAST_EN
  assign bus.m_last    = head[DW];
`endif

endmodule

// File: tb/tb_ram_rd_stream.sv
// tb_ram_rd_stream: directed bench for ram_rd_stream with a behavioural RAM and a queue-based expected-beat model.
// Latency: model expectations are built when a command handshake is observed; checks run every negedge.
// Backpressure: m_ready patterns are driven per cycle; stalled beats must hold m_data (and m_last).
module tb_ram_rd_stream;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_rd_stream_if #(.AW(AW), .DW(DW)) bus ();
  ram_rd_stream #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Behavioural RAM: data appears the cycle after r_en.
  logic [DW-1:0] mem [NW];
  always @(posedge clk) if (bus.r_en) bus.r_data <= mem[bus.r_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_dat [$];
  logic [AW-1:0] exp_adr [$];
  bit            exp_lst [$];
  logic [DW-1:0] got_dat [$];
  logic [AW-1:0] got_adr [$];
  bit            got_lst [$];

  int hs_cnt = 0, ren_cnt = 0, ren_before_pop = 0, mvalid_cnt = 0, done_cnt = 0;
  int acc_cyc = 0, first_vld_cyc = -1, first_hs_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  logic busy_at_done = 1'b0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_dat = '0;
  bit prev_lst = 1'b0;

  logic [7:0] seq8 [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFD, 8'h07};
  logic [4:0] wrap_adr [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
  logic [7:0] wrap_dat [4] = '{8'h1E, 8'h1F, 8'h00, 8'h01};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model and per-cycle compare, evaluated at each negedge.
  task automatic monitor();
    if (rst) begin
      exp_dat.delete(); exp_adr.delete(); exp_lst.delete();
      prev_stall = 1'b0;
      return;
    end
    if (bus.cmd_valid && bus.cmd_ready) begin
      exp_dat.delete(); exp_adr.delete(); exp_lst.delete();
      got_dat.delete(); got_adr.delete(); got_lst.delete();
      hs_cnt = 0; ren_cnt = 0; ren_before_pop = 0; mvalid_cnt = 0; done_cnt = 0;
      first_vld_cyc = -1; acc_cyc = cyc;
      for (int i = 0; i < int'(bus.cmd_len); i++) begin
        int a;
        a = (int'(bus.cmd_addr) + i) % NW;
        exp_adr.push_back(AW'(a));
        exp_dat.push_back(mem[a]);
        exp_lst.push_back(i == int'(bus.cmd_len) - 1);
      end
    end
    if (prev_stall) begin
      chk("stall_valid_held", 32'(bus.m_valid), 1);
      chk("stall_data_held", 32'(bus.m_data), 32'(prev_dat));
`ifdef RAM_RD_STREAM_LAST_EN
      chk("stall_last_held", 32'(bus.m_last), 32'(prev_lst));
`endif
    end
    if (bus.r_en) begin
      ren_cnt++;
      if (hs_cnt == 0) ren_before_pop++;
      got_adr.push_back(bus.r_addr);
      chk("r_en_expected", 32'(exp_adr.size() != 0), 1);
      if (exp_adr.size() != 0) chk("r_addr", 32'(bus.r_addr), 32'(exp_adr.pop_front()));
    end
    if (bus.m_valid) begin
      mvalid_cnt++;
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
    end
    if (bus.m_valid && bus.m_ready) begin
      chk("beat_expected", 32'(exp_dat.size() != 0), 1);
      got_dat.push_back(bus.m_data);
      if (exp_dat.size() != 0) begin
        chk("m_data", 32'(bus.m_data), 32'(exp_dat.pop_front()));
`ifdef RAM_RD_STREAM_LAST_EN
        got_lst.push_back(bus.m_last);
        chk("m_last", 32'(bus.m_last), 32'(exp_lst.pop_front()));
`else
        void'(exp_lst.pop_front());
`endif
      end
      if (hs_cnt == 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      hs_cnt++;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = bus.busy;
      chk("done_all_beats_out", 32'(exp_dat.size()), 0);
    end
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_dat   = bus.m_data;
`ifdef RAM_RD_STREAM_LAST_EN
    prev_lst   = bus.m_last;
`endif
  endtask

  // One clock: compare at negedge, return #1 after the next rising edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
    chk({tag, "_r_en"},      32'(bus.r_en), 0);
    chk({tag, "_r_addr"},    32'(bus.r_addr), 0);
    chk({tag, "_m_valid"},   32'(bus.m_valid), 0);
    chk({tag, "_m_data"},    32'(bus.m_data), 0);
    chk({tag, "_busy"},      32'(bus.busy), 0);
    chk({tag, "_done"},      32'(bus.done), 0);
`ifdef RAM_RD_STREAM_LAST_EN
    chk({tag, "_m_last"},    32'(bus.m_last), 0);
`endif
  endtask

  // mode 0: m_ready always high; mode 1: low for 6 cycles, then alternating.
  task automatic burst(input int addr, input int len, input int mode);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr[AW-1:0];
    bus.cmd_len   = len[AW:0];
    bus.m_ready   = 1'b0;
    step();
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 200 && done_cnt == 0; k++) begin
      bus.m_ready = (mode == 0) ? 1'b1 : ((k <= 6) ? 1'b0 : k[0]);
      step();
    end
    chk("done_within_budget", 32'(done_cnt), 1);
    chk("cmd_ready_after_done", 32'(bus.cmd_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = DW'(i);
    mem[6] = 8'hFD;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.m_ready   = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk_reset_state("por");

    // Linear burst, no backpressure.
    burst(0, 8, 0);
    chk("b1_beats", 32'(got_dat.size()), 8);
    for (int i = 0; i < 8; i++) chk("b1_seq", 32'(got_dat[i]), 32'(seq8[i]));
    // accept is sampled at the negedge before the accepting edge
    chk("b1_first_valid_lat", 32'(first_vld_cyc - (acc_cyc + 1)), 2);
    chk("b1_no_bubbles", 32'(last_hs_cyc - first_hs_cyc), 7);
    chk("b1_done_after_last", 32'(done_cyc - last_hs_cyc), 1);
    chk("b1_busy_at_done", 32'(busy_at_done), 0);
    chk("b1_reads", 32'(ren_cnt), 8);

    // Address wrap.
    burst(30, 4, 0);
    chk("wrap_reads", 32'(got_adr.size()), 4);
    for (int i = 0; i < 4; i++) chk("wrap_addr", 32'(got_adr[i]), 32'(wrap_adr[i]));
    for (int i = 0; i < 4; i++) chk("wrap_data", 32'(got_dat[i]), 32'(wrap_dat[i]));

    // Backpressure.
    burst(0, 8, 1);
    chk("bp_reads_before_pop", 32'(ren_before_pop), 4);
    chk("bp_beats", 32'(got_dat.size()), 8);
    for (int i = 0; i < 8; i++) chk("bp_seq", 32'(got_dat[i]), 32'(seq8[i]));

    // Zero length.
    burst(7, 0, 0);
    chk("zero_reads", 32'(ren_cnt), 0);
    chk("zero_valid_cycles", 32'(mvalid_cnt), 0);
    chk("zero_done_timing", 32'(done_cyc - acc_cyc), 1);

    // Reset in the middle of a burst.
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = '0;
    bus.cmd_len   = 6'd8;
    bus.m_ready   = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 50 && hs_cnt < 3; k++) step();
    chk("mid_three_beats", 32'(hs_cnt), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_state("mid");
    step();
    chk("mid_no_stale_valid_1", 32'(bus.m_valid), 0);
    step();
    chk("mid_no_stale_valid_2", 32'(bus.m_valid), 0);
    burst(10, 2, 0);
    chk("post_rst_beats", 32'(got_dat.size()), 2);
    chk("post_rst_beat0", 32'(got_dat[0]), 32'h0A);
    chk("post_rst_beat1", 32'(got_dat[1]), 32'h0B);

`ifdef RAM_RD_STREAM_LAST_EN
    burst(0, 3, 0);
    chk("last3_beats", 32'(got_lst.size()), 3);
    chk("last3_b0", 32'(got_lst[0]), 0);
    chk("last3_b1", 32'(got_lst[1]), 0);
    chk("last3_b2", 32'(got_lst[2]), 1);
    burst(5, 1, 0);
    chk("last1_beats", 32'(got_lst.size()), 1);
    chk("last1_b0", 32'(got_lst[0]), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
